// File: rtl/sdram_line_sequencer_if.sv
// Bundle of cache-side request/response and SDRAM-controller command signals for sdram_line_sequencer.
// slave = the sequencer; master = the surrounding cache + controller environment.
interface sdram_line_sequencer_if;
  logic         req;
  logic         req_evict;
  logic [17:0]  req_fetch_addr;
  logic [17:0]  req_evict_addr;
  logic [255:0] req_wr_line;
  logic [7:0]   req_wr_mask;
  logic         busy;
  logic         rsp_valid;
  logic [255:0] rsp_rd_line;
  logic         sdrc_init_done;
  logic         sdrc_cmd_ack;
  logic [31:0]  sdrc_rd_data;
  logic         sdrc_cmd_en;
  logic [2:0]   sdrc_cmd;
  logic [20:0]  sdrc_addr;
  logic [3:0]   sdrc_dqm;
  logic [31:0]  sdrc_wr_data;
  logic [7:0]   sdrc_data_len;

  modport master (
    output req, req_evict, req_fetch_addr, req_evict_addr, req_wr_line, req_wr_mask,
    input  busy, rsp_valid, rsp_rd_line,
    output sdrc_init_done, sdrc_cmd_ack, sdrc_rd_data,
    input  sdrc_cmd_en, sdrc_cmd, sdrc_addr, sdrc_dqm, sdrc_wr_data, sdrc_data_len
  );

  modport slave (
    input  req, req_evict, req_fetch_addr, req_evict_addr, req_wr_line, req_wr_mask,
    output busy, rsp_valid, rsp_rd_line,
    input  sdrc_init_done, sdrc_cmd_ack, sdrc_rd_data,
    output sdrc_cmd_en, sdrc_cmd, sdrc_addr, sdrc_dqm, sdrc_wr_data, sdrc_data_len
  );
endinterface

// File: rtl/sdram_line_sequencer.sv
// Turns one cache-line fetch (or evict+fetch) into ACTIVE/WRITE/READ 8-word bursts and issues periodic refresh.
// Optional SDRAM_SEQ_WORD_MASK_EN: per-word write masking via DQM, all-zero mask skips the evict.
module sdram_line_sequencer #(
  parameter int T_RCD          = 2,
  parameter int READ_LATENCY   = 5,
  parameter int REFRESH_PERIOD = 400
) (
  input logic                    clk,
  input logic                    rst,
  sdram_line_sequencer_if.slave  bus
);
  localparam logic [2:0] CMD_REFRESH = 3'b001;
  localparam logic [2:0] CMD_ACTIVE  = 3'b011;
  localparam logic [2:0] CMD_WRITE   = 3'b100;
  localparam logic [2:0] CMD_READ    = 3'b101;
  localparam int CW = $clog2(T_RCD + READ_LATENCY + 9);
  localparam int RW = $clog2(REFRESH_PERIOD + 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_REF, S_REF_WAIT, S_ACT_W, S_ACT_W_WAIT, S_TRCD_W, S_WR, S_WR_WAIT,
    S_ACT_R, S_ACT_R_WAIT, S_TRCD_R, S_RD, S_RD_WAIT
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  ref_cnt_q, ref_cnt_d;
  logic           ref_pend_q, ref_pend_d;
  logic [17:0]    fetch_addr_q, fetch_addr_d;
  logic [17:0]    evict_addr_q, evict_addr_d;
  logic [255:0]   wr_line_q, wr_line_d;
  logic [255:0]   shift_q, shift_d;
  logic [255:0]   rsp_line_q, rsp_line_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           cmd_en_q, cmd_en_d;
  logic [2:0]     cmd_q, cmd_d;
  logic [20:0]    addr_q, addr_d;
  logic [3:0]     dqm_q, dqm_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic [2:0]     word_idx;
  logic [31:0]    word_data;
  logic [3:0]     word_dqm;
  logic           do_evict;

  assign word_idx  = (state_q == S_WR) ? cnt_q[2:0] : 3'd0;
  assign word_data = wr_line_q[{word_idx, 5'b0} +: 32];

`ifdef SDRAM_SEQ_WORD_MASK_EN
  logic [7:0] wr_mask_q, wr_mask_d;
  assign word_dqm = wr_mask_q[word_idx] ? 4'b0000 : 4'b1111;
  assign do_evict = bus.req_evict && (bus.req_wr_mask != 8'h00);
  assign wr_mask_d = (state_q == S_IDLE && !ref_pend_q && bus.req) ? bus.req_wr_mask : wr_mask_q;
  always_ff @(posedge clk) begin
    if (rst) wr_mask_q <= '0;
    else     wr_mask_q <= wr_mask_d;
  end
`else
  logic unused_mask;
  assign unused_mask = ^bus.req_wr_mask;
  assign word_dqm = 4'b0000;
  assign do_evict = bus.req_evict;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ref_cnt_d    = ref_cnt_q;
    ref_pend_d   = ref_pend_q;
    fetch_addr_d = fetch_addr_q;
    evict_addr_d = evict_addr_q;
    wr_line_d    = wr_line_q;
    shift_d      = shift_q;
    rsp_line_d   = rsp_line_q;
    rsp_valid_d  = 1'b0;
    cmd_en_d     = 1'b0;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    dqm_d        = dqm_q;
    wr_data_d    = wr_data_q;
    case (state_q)
      S_INIT: if (bus.sdrc_init_done) state_d = S_IDLE;
      S_IDLE: begin
        // A pending refresh takes the slot; a same-cycle req is dropped and must be retried.
        if (ref_pend_q) begin
          ref_pend_d = 1'b0;
          cmd_en_d   = 1'b1;
          cmd_d      = CMD_REFRESH;
          state_d    = S_REF;
        end else if (bus.req) begin
          fetch_addr_d = bus.req_fetch_addr;
          evict_addr_d = bus.req_evict_addr;
          wr_line_d    = bus.req_wr_line;
          cmd_en_d     = 1'b1;
          cmd_d        = CMD_ACTIVE;
          dqm_d        = 4'b0000;
          if (do_evict) begin
            addr_d  = {bus.req_evict_addr, 3'b000};
            state_d = S_ACT_W;
          end else begin
            addr_d  = {bus.req_fetch_addr, 3'b000};
            state_d = S_ACT_R;
          end
        end
      end
      S_REF:        state_d = S_REF_WAIT;
      S_REF_WAIT:   if (bus.sdrc_cmd_ack) state_d = S_IDLE;
      S_ACT_W:      state_d = S_ACT_W_WAIT;
      S_ACT_W_WAIT: if (bus.sdrc_cmd_ack) begin cnt_d = '0; state_d = S_TRCD_W; end
      S_TRCD_W: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(T_RCD - 1)) begin
          cmd_en_d  = 1'b1;
          cmd_d     = CMD_WRITE;
          addr_d    = {evict_addr_q, 3'b000};
          wr_data_d = word_data;
          dqm_d     = word_dqm;
          cnt_d     = CW'(1);
          state_d   = S_WR;
        end
      end
      S_WR: begin
        wr_data_d = word_data;
        dqm_d     = word_dqm;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(7)) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        // Write ack means auto-precharge finished; open the fetch row next.
        if (bus.sdrc_cmd_ack) begin
          cmd_en_d = 1'b1;
          cmd_d    = CMD_ACTIVE;
          addr_d   = {fetch_addr_q, 3'b000};
          dqm_d    = 4'b0000;
          state_d  = S_ACT_R;
        end
      end
      S_ACT_R:      state_d = S_ACT_R_WAIT;
      S_ACT_R_WAIT: if (bus.sdrc_cmd_ack) begin cnt_d = '0; state_d = S_TRCD_R; end
      S_TRCD_R: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(T_RCD - 1)) begin
          cmd_en_d = 1'b1;
          cmd_d    = CMD_READ;
          addr_d   = {fetch_addr_q, 3'b000};
          state_d  = S_RD;
        end
      end
      S_RD: begin
        cnt_d   = CW'(1);
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // cnt counts cycles since READ; words arrive in order and shift down from the top.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q >= CW'(READ_LATENCY)) shift_d = {bus.sdrc_rd_data, shift_q[255:32]};
        if (cnt_q == CW'(READ_LATENCY + 7)) begin
          rsp_line_d  = {bus.sdrc_rd_data, shift_q[255:32]};
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
    if (state_q != S_INIT) begin
      if (ref_cnt_q == RW'(REFRESH_PERIOD - 1)) begin
        ref_cnt_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      ref_cnt_q    <= '0;
      ref_pend_q   <= 1'b0;
      fetch_addr_q <= '0;
      evict_addr_q <= '0;
      wr_line_q    <= '0;
      shift_q      <= '0;
      rsp_line_q   <= '0;
      rsp_valid_q  <= 1'b0;
      cmd_en_q     <= 1'b0;
      cmd_q        <= '0;
      addr_q       <= '0;
      dqm_q        <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_pend_q   <= ref_pend_d;
      fetch_addr_q <= fetch_addr_d;
      evict_addr_q <= evict_addr_d;
      wr_line_q    <= wr_line_d;
      shift_q      <= shift_d;
      rsp_line_q   <= rsp_line_d;
      rsp_valid_q  <= rsp_valid_d;
      cmd_en_q     <= cmd_en_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      dqm_q        <= dqm_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.busy          = (state_q != S_IDLE) || ref_pend_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rd_line   = rsp_line_q;
  assign bus.sdrc_cmd_en   = cmd_en_q;
  assign bus.sdrc_cmd      = cmd_q;
  assign bus.sdrc_addr     = addr_q;
  assign bus.sdrc_dqm      = dqm_q;
  assign bus.sdrc_wr_data  = wr_data_q;
  assign bus.sdrc_data_len = 8'd7;
endmodule

// File: tb/tb_sdram_line_sequencer.sv
// Scoreboard bench for sdram_line_sequencer against a behavioural SDRAM-controller model.
// Define SDRAM_SEQ_WORD_MASK_EN to also exercise the masked-write variant.
module tb_sdram_line_sequencer;
  localparam int T_RCD = 2;
  localparam int RL    = 5;
  localparam int P     = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_line_sequencer_if bus ();
  sdram_line_sequencer #(.T_RCD(T_RCD), .READ_LATENCY(RL), .REFRESH_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- controller + SDRAM model ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [logic [20:0]];
  int init_cnt = 0, pending = 0, ack_at = -1, last_ack_cyc = -1000;
  int rd_start = -1000, wr_start = -1000;
  logic [20:0] rd_addr = '0, wr_addr = '0;
  int n_ref = 0, n_act = 0, n_rd = 0, n_wr = 0, last_ref_cyc = 0;

  function automatic logic [31:0] mrd(input logic [20:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      init_cnt = 0; pending = 0; ack_at = -1; rd_start = -1000; wr_start = -1000;
      bus.sdrc_init_done = 1'b0; bus.sdrc_cmd_ack = 1'b0; bus.sdrc_rd_data = 32'h0;
    end else begin
      if (init_cnt < 10) init_cnt++; else bus.sdrc_init_done = 1'b1;
      bus.sdrc_cmd_ack = 1'b0;
      if (ack_at == cyc) begin bus.sdrc_cmd_ack = 1'b1; pending = 0; last_ack_cyc = cyc; end
      if (bus.sdrc_cmd_en === 1'b1) begin
        check("cmd_overlap", 256'(pending), 256'(0));
        check("cmd_in_read_burst", 256'(cyc > rd_start + 7), 256'(1));
        check("data_len", 256'(bus.sdrc_data_len), 256'(7));
        check("addr_col_low", 256'(bus.sdrc_addr[2:0]), 256'(0));
        pending = 1;
        case (bus.sdrc_cmd)
          3'b001: begin n_ref++; last_ref_cyc = cyc; ack_at = cyc + 4; end
          3'b011: begin n_act++; ack_at = cyc + 3; end
          3'b100: begin
            n_wr++; wr_start = cyc; wr_addr = bus.sdrc_addr; ack_at = cyc + 10;
            check("trcd_write", 256'(cyc - last_ack_cyc >= T_RCD + 1), 256'(1));
          end
          3'b101: begin
            n_rd++; rd_start = cyc + RL; rd_addr = bus.sdrc_addr; ack_at = cyc + 2;
            check("trcd_read", 256'(cyc - last_ack_cyc >= T_RCD + 1), 256'(1));
          end
          default: check("cmd_code", 256'(bus.sdrc_cmd), 256'(3'b101));
        endcase
      end
      if (cyc >= wr_start && cyc < wr_start + 8) begin
        logic [20:0] a;
        logic [31:0] w;
        a = wr_addr + 21'(cyc - wr_start);
        w = mrd(a);
        for (int b = 0; b < 4; b++) if (!bus.sdrc_dqm[b]) w[8*b +: 8] = bus.sdrc_wr_data[8*b +: 8];
        mem[a] = w;
      end
      if (cyc >= rd_start && cyc < rd_start + 8) bus.sdrc_rd_data = mrd(rd_addr + 21'(cyc - rd_start));
      else                                       bus.sdrc_rd_data = 32'hdead_beef;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 required no outstanding request");
      end else begin
        check("rsp_line", bus.rsp_rd_line, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [255:0] line0, line_a, line_b, line_c, cur0;

  task automatic wait_idle(input string name);
    int t = 0;
    while (bus.busy !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin n_cmp++; n_bad++; $display("FAIL %s_timeout: got busy=%b required 0", name, bus.busy); end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin n_cmp++; n_bad++; $display("FAIL %s_timeout: got %0d pending required 0", name, exp_q.size()); end
  endtask

  task automatic issue(input logic ev, input logic [17:0] fa, input logic [17:0] ea,
                       input logic [255:0] line, input logic [7:0] mask, input logic [255:0] exp);
    wait_idle("issue_idle");
    bus.req = 1'b1; bus.req_evict = ev; bus.req_fetch_addr = fa; bus.req_evict_addr = ea;
    bus.req_wr_line = line; bus.req_wr_mask = mask;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.req = 1'b0; bus.req_fetch_addr = ~fa; bus.req_evict_addr = ~ea; bus.req_wr_line = ~line;
    drain("issue_rsp");
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 256'(bus.busy), 256'(1));
    check("rst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
    check("rst_rsp_line", bus.rsp_rd_line, 256'(0));
    check("rst_cmd_en", 256'(bus.sdrc_cmd_en), 256'(0));
    check("rst_cmd", 256'(bus.sdrc_cmd), 256'(0));
    check("rst_addr", 256'(bus.sdrc_addr), 256'(0));
    check("rst_dqm", 256'(bus.sdrc_dqm), 256'(0));
    check("rst_wr_data", 256'(bus.sdrc_wr_data), 256'(0));
    check("rst_data_len", 256'(bus.sdrc_data_len), 256'(7));
  endtask

  initial begin
    int a0, r0, w0, t;
    for (int i = 0; i < 8; i++) begin
      line0[32*i +: 32]  = (i == 0) ? 32'h1234_5678 : 32'habcd_ef00 + 32'(i);
      line_a[32*i +: 32] = 32'haaaa_0000 | 32'(i);
      line_b[32*i +: 32] = 32'hbbbb_0000 | 32'(i);
      line_c[32*i +: 32] = 32'hcccc_0000 | 32'(i);
    end
    bus.req = 1'b0; bus.req_evict = 1'b0; bus.req_fetch_addr = '0; bus.req_evict_addr = '0;
    bus.req_wr_line = '0; bus.req_wr_mask = 8'hff;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    wait_idle("init");

    issue(1'b1, 18'h0, 18'h0, line0, 8'hff, line0);        // evict then fetch same line
    issue(1'b1, 18'h0, 18'h20, line_a, 8'hff, line0);      // row 1 written, row 0 read back
    issue(1'b0, 18'h20, 18'h0, line_c, 8'hff, line_a);
    issue(1'b1, 18'h21, 18'h20, line_b, 8'hff, 256'(0));   // same row evict+fetch
    issue(1'b0, 18'h20, 18'h0, line_c, 8'hff, line_b);
    cur0 = line0;
`ifdef SDRAM_SEQ_WORD_MASK_EN
    cur0 = line0;
    cur0[31:0] = line_c[31:0];
    cur0[95:64] = line_c[95:64];
    issue(1'b1, 18'h0, 18'h0, line_c, 8'b0000_0101, cur0);
    w0 = n_wr;
    issue(1'b1, 18'h0, 18'h20, line_c, 8'h00, cur0);
    check("mask0_no_write", 256'(n_wr - w0), 256'(0));
    issue(1'b0, 18'h20, 18'h0, line_c, 8'hff, line_b);
`else
    w0 = n_wr;
    issue(1'b1, 18'h40, 18'h40, line_c, 8'h00, line_c);    // mask ignored: full line written
    check("nomask_write_count", 256'(n_wr - w0), 256'(1));
`endif

    // req held high while busy: exactly one service
    wait_idle("hold_idle");
    a0 = n_act;
    bus.req = 1'b1; bus.req_evict = 1'b0; bus.req_fetch_addr = 18'h0;
    exp_q.push_back(cur0);
    repeat (10) @(negedge clk);
    bus.req = 1'b0;
    drain("hold_rsp");
    repeat (20) @(negedge clk);
    check("hold_single_act", 256'(n_act - a0), 256'(1));

    // refresh cadence while idle
    r0 = n_ref; t = 0;
    while (n_ref == r0 && t < 2 * P) begin @(negedge clk); t++; end
    check("refresh_seen", 256'(n_ref != r0), 256'(1));
    r0 = n_ref;
    repeat (2 * P + P / 2) @(negedge clk);
    check("refresh_count", 256'(n_ref - r0), 256'(2));

    // req in the cycle a refresh becomes due: refresh first, req dropped
    while (cyc < last_ref_cyc + P - 1) @(negedge clk);
    a0 = n_act;
    bus.req = 1'b1; bus.req_evict = 1'b0; bus.req_fetch_addr = 18'h0;
    check("busy_ref_pending", 256'(bus.busy), 256'(1));
    @(negedge clk);
    bus.req = 1'b0;
    check("ref_first_cmd", 256'({bus.sdrc_cmd_en, bus.sdrc_cmd}), 256'(4'b1001));
    wait_idle("ref_idle");
    repeat (30) @(negedge clk);
    check("ref_req_ignored", 256'(n_act - a0), 256'(0));

    // reset in the middle of a read burst
    wait_idle("rst_idle");
    r0 = n_rd;
    bus.req = 1'b1; bus.req_evict = 1'b0; bus.req_fetch_addr = 18'h0;
    exp_q.push_back(cur0);
    @(negedge clk);
    bus.req = 1'b0;
    t = 0;
    while (n_rd == r0 && t < 100) begin @(negedge clk); t++; end
    check("rd_before_rst", 256'(n_rd != r0), 256'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    wait_idle("reinit");
    issue(1'b0, 18'h0, 18'h0, line_c, 8'hff, cur0);

    drain("final");
    check("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
